// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Runs a caller-selected list of operations (ADD, SUB, MULT, DIV, MOD) on one
// latched operand pair through the shared 3-bit arithmetic unit. Each result
// is shown on the LED bank for at least DWELL cycles, then offered downstream.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake; req_a, req_b operands,
//                              req_mask ops to run (bit0 ADD .. bit4 MOD)
//   alu_a, alu_b, alu_sel      registered drive of the arithmetic unit
//   alu_result                 combinational unit result for alu_sel
//   res_valid/res_ready        result handshake; res_op, res_data, res_err
//   done                       one-cycle pulse after the last op of a request
//   leds                       res_data while a result is held, else 0
module alu_op_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    input  logic [4:0] req_mask,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [5:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] res_op,
    output logic [5:0] res_data,
    output logic       res_err,
    output logic       done,
    output logic [5:0] leds
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [2:0] OP_DIV     = 3'd3;
    localparam logic [2:0] OP_MOD     = 3'd4;

    // Lowest set bit of an op mask; ops therefore run in ascending code order.
    function automatic logic [2:0] lowest_op(input logic [4:0] m);
        logic [2:0] r;
        casez (m)
            5'b????1: r = 3'd0;
            5'b???10: r = 3'd1;
            5'b??100: r = 3'd2;
            5'b?1000: r = 3'd3;
            5'b10000: r = 3'd4;
            default:  r = 3'd0;
        endcase
        return r;
    endfunction

    state_t     state_r, state_s;
    logic [2:0] a_r, a_s;
    logic [2:0] b_r, b_s;
    logic [4:0] mask_r, mask_s;
    logic [2:0] idx_r, idx_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] alu_a_r, alu_a_s;
    logic [2:0] alu_b_r, alu_b_s;
    logic [2:0] alu_sel_r, alu_sel_s;
    logic       res_valid_r, res_valid_s;
    logic [2:0] res_op_r, res_op_s;
    logic [5:0] res_data_r, res_data_s;
    logic       res_err_r, res_err_s;
    logic       done_r, done_s;
    logic [5:0] leds_r, leds_s;
    logic [4:0] remaining_s;
    logic       div_zero_s;

    assign req_ready   = (state_r == IDLE);
    assign remaining_s = mask_r & ~(5'b00001 << idx_r);
    assign div_zero_s  = ((idx_r == OP_DIV) || (idx_r == OP_MOD)) && (b_r == 3'd0);

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign res_valid = res_valid_r;
    assign res_op    = res_op_r;
    assign res_data  = res_data_r;
    assign res_err   = res_err_r;
    assign done      = done_r;
    assign leds      = leds_r;

    // Next-state and next-output computation for every registered signal.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        mask_s      = mask_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        alu_a_s     = alu_a_r;
        alu_b_s     = alu_b_r;
        alu_sel_s   = alu_sel_r;
        res_valid_s = res_valid_r;
        res_op_s    = res_op_r;
        res_data_s  = res_data_r;
        res_err_s   = res_err_r;
        done_s      = 1'b0;
        leds_s      = 6'd0;

        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    a_s    = req_a;
                    b_s    = req_b;
                    mask_s = req_mask;
                    idx_s  = lowest_op(req_mask);
                    if (req_mask == 5'd0) begin
                        state_s = DONE;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                alu_a_s   = a_r;
                alu_b_s   = b_r;
                alu_sel_s = idx_r;
                state_s   = CAPTURE;
            end
            CAPTURE: begin
                res_op_s = idx_r;
                // A zero divisor makes the unit's output meaningless; flag it instead.
                if (div_zero_s) begin
                    res_data_s = 6'd0;
                    res_err_s  = 1'b1;
                end else begin
                    res_data_s = alu_result;
                    res_err_s  = 1'b0;
                end
                cnt_s       = 8'd0;
                res_valid_s = (DWELL_LAST == 8'd0);
                state_s     = HOLD;
            end
            HOLD: begin
                if (res_valid_r && res_ready) begin
                    res_valid_s = 1'b0;
                    mask_s      = remaining_s;
                    if (remaining_s != 5'd0) begin
                        idx_s   = lowest_op(remaining_s);
                        state_s = ISSUE;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    // Counter saturates so res_valid stays up under backpressure.
                    if (cnt_r != DWELL_LAST) begin
                        cnt_s = cnt_r + 8'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    res_valid_s = (cnt_s == DWELL_LAST);
                    state_s     = HOLD;
                end
            end
            DONE: begin
                res_valid_s = 1'b0;
                state_s     = IDLE;
            end
            default: begin
                res_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        if (state_s == DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
        if (state_s == HOLD) begin
            leds_s = res_data_s;
        end else begin
            leds_s = 6'd0;
        end
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= 3'd0;
            b_r         <= 3'd0;
            mask_r      <= 5'd0;
            idx_r       <= 3'd0;
            cnt_r       <= 8'd0;
            alu_a_r     <= 3'd0;
            alu_b_r     <= 3'd0;
            alu_sel_r   <= 3'd0;
            res_valid_r <= 1'b0;
            res_op_r    <= 3'd0;
            res_data_r  <= 6'd0;
            res_err_r   <= 1'b0;
            done_r      <= 1'b0;
            leds_r      <= 6'd0;
        end else begin
            state_r     <= state_s;
            a_r         <= a_s;
            b_r         <= b_s;
            mask_r      <= mask_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            alu_a_r     <= alu_a_s;
            alu_b_r     <= alu_b_s;
            alu_sel_r   <= alu_sel_s;
            res_valid_r <= res_valid_s;
            res_op_r    <= res_op_s;
            res_data_r  <= res_data_s;
            res_err_r   <= res_err_s;
            done_r      <= done_s;
            leds_r      <= leds_s;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed table vectors, hand-written
// multi-cycle sequences (zero mask with a stalled second request, reset in
// the middle of a held result) and randomized requests checked against a
// behavioural model of the expected result list.
module tb_alu_op_sequencer;

    localparam int DWELL = 4;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_a;
    logic [2:0] req_b;
    logic [4:0] req_mask;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [2:0] alu_sel;
    logic [5:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_op;
    logic [5:0] res_data;
    logic       res_err;
    logic       done;
    logic [5:0] leds;
    logic       force63;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [2:0]      a;
        logic [2:0]      b;
        logic [4:0]      mask;
        logic            force63;
        int              hold;
        int              n;
        logic [4:0][2:0] ops;
        logic [4:0][5:0] data;
        logic [4:0]      errs;
    } vec_t;

    vec_t vecs[6];

    alu_op_sequencer #(.DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mask   (req_mask),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_op     (res_op),
        .res_data   (res_data),
        .res_err    (res_err),
        .done       (done),
        .leds       (leds)
    );

    // Arithmetic unit stand-in; a zero divisor yields 63 as a garbage value.
    always_comb begin
        alu_result = 6'd63;
        if (force63) begin
            alu_result = 6'd63;
        end else begin
            case (alu_sel)
                3'd0: alu_result = {2'b00, {1'b0, alu_a} + {1'b0, alu_b}};
                3'd1: alu_result = {3'b000, alu_a - alu_b};
                3'd2: alu_result = {3'b000, alu_a} * {3'b000, alu_b};
                3'd3: if (alu_b != 3'd0) alu_result = {3'b000, alu_a / alu_b};
                3'd4: if (alu_b != 3'd0) alu_result = {3'b000, alu_a % alu_b};
                default: alu_result = 6'd63;
            endcase
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result list from the arithmetic rules, in ascending op order.
    task automatic model(input logic [2:0] a, input logic [2:0] b, input logic [4:0] mask,
                         output int n, output logic [4:0][2:0] ops,
                         output logic [4:0][5:0] data, output logic [4:0] errs);
        int ai;
        int bi;
        int r;
        logic e;
        ai = int'(a);
        bi = int'(b);
        n = 0;
        ops = '0;
        data = '0;
        errs = '0;
        for (int op = 0; op < 5; op++) begin
            if (mask[op]) begin
                e = 1'b0;
                r = 0;
                case (op)
                    0: r = ai + bi;
                    1: r = (ai - bi + 8) % 8;
                    2: r = ai * bi;
                    3: if (bi == 0) e = 1'b1; else r = ai / bi;
                    default: if (bi == 0) e = 1'b1; else r = ai % bi;
                endcase
                ops[n]  = 3'(op);
                data[n] = 6'(r);
                errs[n] = e;
                n++;
            end
        end
    endtask

    // Present a request (called at a negedge) and return on its acceptance negedge.
    task automatic send_req(input logic [2:0] a, input logic [2:0] b, input logic [4:0] m);
        int w;
        w = 0;
        req_a = a;
        req_b = b;
        req_mask = m;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("req_accept", req_ready, 1);
    endtask

    // Follow an accepted request through all its results and the done pulse.
    task automatic check_seq(input int n, input logic [4:0][2:0] ops,
                             input logic [4:0][5:0] data, input logic [4:0] errs,
                             input int hold);
        int cyc;
        logic busy_ok;
        logic stable_ok;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            busy_ok = 1'b1;
            do begin
                @(negedge clk);
                cyc++;
                req_valid = 1'b0;
                res_ready = (hold == 0);
                if (req_ready !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
            end while (res_valid !== 1'b1 && cyc < 50);
            check("busy_no_ready_no_done", busy_ok, 1);
            check("result_latency", cyc, 2 + DWELL);
            check("res_op", res_op, ops[i]);
            check("res_data", res_data, data[i]);
            check("res_err", res_err, errs[i]);
            check("leds", leds, data[i]);
            stable_ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_op !== ops[i] || res_data !== data[i] ||
                    res_err !== errs[i] || leds !== data[i]) stable_ok = 1'b0;
            end
            if (hold > 0) check("backpressure_stable", stable_ok, 1);
            res_ready = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("done_pulse", done, 1);
        check("done_no_valid", res_valid, 0);
        check("done_leds_off", leds, 0);
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("idle_ready", req_ready, 1);
    endtask

    initial begin
        int n;
        int w;
        int hold;
        logic ok;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [4:0] rm;
        logic [4:0][2:0] ops;
        logic [4:0][5:0] data;
        logic [4:0] errs;

        n_compared = 0;
        n_mismatched = 0;

        vecs[0] = '{a: 3'd5, b: 3'd3, mask: 5'b11111, force63: 1'b0, hold: 0, n: 5,
                    ops: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                    data: {6'd2, 6'd1, 6'd15, 6'd2, 6'd8}, errs: 5'b00000};
        vecs[1] = '{a: 3'd2, b: 3'd5, mask: 5'b00010, force63: 1'b0, hold: 0, n: 1,
                    ops: {3'd0, 3'd0, 3'd0, 3'd0, 3'd1},
                    data: {6'd0, 6'd0, 6'd0, 6'd0, 6'd5}, errs: 5'b00000};
        vecs[2] = '{a: 3'd6, b: 3'd0, mask: 5'b11000, force63: 1'b1, hold: 0, n: 2,
                    ops: {3'd0, 3'd0, 3'd0, 3'd4, 3'd3},
                    data: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, errs: 5'b00011};
        vecs[3] = '{a: 3'd7, b: 3'd7, mask: 5'b00100, force63: 1'b0, hold: 10, n: 1,
                    ops: {3'd0, 3'd0, 3'd0, 3'd0, 3'd2},
                    data: {6'd0, 6'd0, 6'd0, 6'd0, 6'd49}, errs: 5'b00000};
        vecs[4] = '{a: 3'd7, b: 3'd7, mask: 5'b00011, force63: 1'b0, hold: 2, n: 2,
                    ops: {3'd0, 3'd0, 3'd0, 3'd1, 3'd0},
                    data: {6'd0, 6'd0, 6'd0, 6'd0, 6'd14}, errs: 5'b00000};
        vecs[5] = '{a: 3'd7, b: 3'd1, mask: 5'b11000, force63: 1'b0, hold: 1, n: 2,
                    ops: {3'd0, 3'd0, 3'd0, 3'd4, 3'd3},
                    data: {6'd0, 6'd0, 6'd0, 6'd0, 6'd7}, errs: 5'b00000};

        rst_n = 1'b1;
        req_valid = 1'b0;
        req_a = 3'd0;
        req_b = 3'd0;
        req_mask = 5'd0;
        res_ready = 1'b0;
        force63 = 1'b0;

        // Reset state.
        #2 rst_n = 1'b0;
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_leds", leds, 0);
        check("rst_res_data", res_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            force63 = vecs[v].force63;
            send_req(vecs[v].a, vecs[v].b, vecs[v].mask);
            check_seq(vecs[v].n, vecs[v].ops, vecs[v].data, vecs[v].errs, vecs[v].hold);
            force63 = 1'b0;
        end

        // Zero mask: done follows acceptance; a second request stalls until IDLE.
        send_req(3'd0, 3'd0, 5'd0);
        @(negedge clk);
        req_a = 3'd3;
        req_b = 3'd4;
        req_mask = 5'b10101;
        check("mask0_done", done, 1);
        check("mask0_no_valid", res_valid, 0);
        check("stall_req_ready", req_ready, 0);
        @(negedge clk);
        check("mask0_done_cleared", done, 0);
        check("stall_accept_ready", req_ready, 1);
        model(3'd3, 3'd4, 5'b10101, n, ops, data, errs);
        check_seq(n, ops, data, errs, 0);

        // Reset while a result is held under backpressure.
        res_ready = 1'b0;
        send_req(3'd5, 3'd3, 5'b00100);
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (res_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("pre_reset_valid", res_valid, 1);
        check("pre_reset_data", res_data, 15);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_data", res_data, 0);
        check("midrst_res_op", res_op, 0);
        check("midrst_leds", leds, 0);
        check("midrst_alu_sel", alu_sel, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_b", alu_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
        end
        check("midrst_no_done", ok, 1);
        send_req(vecs[0].a, vecs[0].b, vecs[0].mask);
        check_seq(vecs[0].n, vecs[0].ops, vecs[0].data, vecs[0].errs, 0);

        // Randomized requests against the model.
        for (int t = 0; t < 40; t++) begin
            ra = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            rm = 5'($urandom_range(0, 31));
            hold = int'($urandom_range(0, 3));
            model(ra, rb, rm, n, ops, data, errs);
            send_req(ra, rb, rm);
            check_seq(n, ops, data, errs, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
